// File: rtl/alu_operand_select.sv
// alu_operand_select
// Execute-stage operand and function selector for the Y86-64 sequential core.
// Decodes icode/ifun into ALU operand A, operand B and the 2-bit ALU function,
// then captures the result in a single output register stage.
//
// Optional feature macro: ALU_SEL_IADDQ_EN
//   defined   -> icode C (iaddq) selects aluA=valC, aluB=valB, alufun=ADD
//   undefined -> icode C decodes as an unknown instruction (all-zero operands)
//
// Flow control: this stage has no ready signal. in_valid marks that the
// inputs carry a decoded instruction. The register loads on every edge
// unless stall=1, which freezes every output including out_valid. rst has
// priority over stall. The data outputs load even when in_valid=0, so
// consumers must qualify aluA/aluB/alufun/fun_err with out_valid.

module alu_operand_select (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        stall,
    input  logic [3:0]  icode,
    input  logic [3:0]  ifun,
    input  logic [63:0] valA,
    input  logic [63:0] valB,
    input  logic [63:0] valC,
    output logic        out_valid,
    output logic [63:0] aluA,
    output logic [63:0] aluB,
    output logic [1:0]  alufun,
    output logic        fun_err
);

    // Instruction codes
    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [3:0] I_IADDQ  = 4'hC;

    // ALU function codes
    localparam logic [1:0] F_ADD = 2'd0;

    // Stack pointer adjustment constants
    localparam logic [63:0] MINUS_8 = 64'hFFFF_FFFF_FFFF_FFF8;
    localparam logic [63:0] PLUS_8  = 64'd8;

    // Operand source selectors, kept as named enums so the decode is readable
    // and easy to observe in a waveform.
    typedef enum logic [2:0] {
        A_ZERO   = 3'd0,
        A_VALA   = 3'd1,
        A_VALC   = 3'd2,
        A_MINUS8 = 3'd3,
        A_PLUS8  = 3'd4
    } a_src_e;

    typedef enum logic {
        B_ZERO = 1'b0,
        B_VALB = 1'b1
    } b_src_e;

    a_src_e     a_src;
    b_src_e     b_src;
    logic [1:0] fun_sel;
    logic       err_sel;

    logic [63:0] aluA_next;
    logic [63:0] aluB_next;

    // Decode icode/ifun into operand sources and ALU function.
    always_comb begin
        a_src   = A_ZERO;
        b_src   = B_ZERO;
        fun_sel = F_ADD;
        err_sel = 1'b0;
        case (icode)
            I_HALT, I_NOP, I_JXX: begin
                a_src = A_ZERO;
                b_src = B_ZERO;
            end
            I_RRMOVQ: begin
                a_src = A_VALA;
                b_src = B_ZERO;
            end
            I_IRMOVQ: begin
                a_src = A_VALC;
                b_src = B_ZERO;
            end
            I_RMMOVQ, I_MRMOVQ: begin
                a_src = A_VALC;
                b_src = B_VALB;
            end
            I_OPQ: begin
                a_src = A_VALA;
                b_src = B_VALB;
                // Only ifun 0..3 name a real ALU operation; anything larger
                // falls back to ADD and raises the error flag.
                if (ifun[3:2] == 2'b00) begin
                    fun_sel = ifun[1:0];
                end else begin
                    fun_sel = F_ADD;
                    err_sel = 1'b1;
                end
            end
            I_CALL, I_PUSHQ: begin
                a_src = A_MINUS8;
                b_src = B_VALB;
            end
            I_RET, I_POPQ: begin
                a_src = A_PLUS8;
                b_src = B_VALB;
            end
`ifdef ALU_SEL_IADDQ_EN
            I_IADDQ: begin
                a_src = A_VALC;
                b_src = B_VALB;
            end
`endif
            default: begin
                // Unknown codes select zero operands with ADD.
                a_src = A_ZERO;
                b_src = B_ZERO;
            end
        endcase
    end

    // Operand multiplexers driven by the decoded sources.
    always_comb begin
        aluA_next = 64'd0;
        aluB_next = 64'd0;
        case (a_src)
            A_VALA:   aluA_next = valA;
            A_VALC:   aluA_next = valC;
            A_MINUS8: aluA_next = MINUS_8;
            A_PLUS8:  aluA_next = PLUS_8;
            default:  aluA_next = 64'd0;
        endcase
        if (b_src == B_VALB) begin
            aluB_next = valB;
        end
    end

    // Output register: reset first, then stall holds, otherwise load.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            aluA      <= 64'd0;
            aluB      <= 64'd0;
            alufun    <= F_ADD;
            fun_err   <= 1'b0;
        end else if (!stall) begin
            out_valid <= in_valid;
            aluA      <= aluA_next;
            aluB      <= aluB_next;
            alufun    <= fun_sel;
            fun_err   <= err_sel;
        end
    end

endmodule

// File: tb/tb_alu_operand_select.sv
// tb_alu_operand_select
// Table-driven vectors, hand-written stall/reset sequences and a randomized
// phase, all compared against a lookup-table reference model of the stage.
// Honors ALU_SEL_IADDQ_EN the same way as the design.

module tb_alu_operand_select;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        stall;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [63:0] valC;
    logic        out_valid;
    logic [63:0] aluA;
    logic [63:0] aluB;
    logic [1:0]  alufun;
    logic        fun_err;

    int n_total;
    int n_pass;

    alu_operand_select dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .stall     (stall),
        .icode     (icode),
        .ifun      (ifun),
        .valA      (valA),
        .valB      (valB),
        .valC      (valC),
        .out_valid (out_valid),
        .aluA      (aluA),
        .aluB      (aluB),
        .alufun    (alufun),
        .fun_err   (fun_err)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Output bundle layout: {out_valid, fun_err, alufun, aluB, aluA}
    typedef logic [131:0] obits_t;

    // Operand A source per icode: 0 zero, 1 valA, 2 valC, 3 -8, 4 +8
    int a_kind [16];
    // Which icodes feed valB into operand B
    bit b_uses [16];

    obits_t exp_reg;

    function automatic obits_t model_sel(input logic v, input logic [3:0] ic, input logic [3:0] fn,
                                         input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
        logic [63:0] ra;
        logic [63:0] rb;
        logic [1:0]  rf;
        logic        re;
        case (a_kind[ic])
            1:       ra = a;
            2:       ra = c;
            3:       ra = 64'd0 - 64'd8;
            4:       ra = 64'd8;
            default: ra = 64'd0;
        endcase
        rb = b_uses[ic] ? b : 64'd0;
        rf = 2'd0;
        re = 1'b0;
        if (ic == 4'd6) begin
            if (fn <= 4'd3) rf = fn[1:0];
            else            re = 1'b1;
        end
        return {v, re, rf, rb, ra};
    endfunction

    task automatic check(input string name, input obits_t exp);
        obits_t act;
        act = {out_valid, fun_err, alufun, aluB, aluA};
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got v=%0b err=%0b fun=%0d B=%h A=%h, want v=%0b err=%0b fun=%0d B=%h A=%h",
                      name, act[131], act[130], act[129:128], act[127:64], act[63:0],
                      exp[131], exp[130], exp[129:128], exp[127:64], exp[63:0]);
    endtask

    // Apply one edge with the currently driven inputs, advance the model, check.
    task automatic step(input string name);
        if (rst)         exp_reg = '0;
        else if (!stall) exp_reg = model_sel(in_valid, icode, ifun, valA, valB, valC);
        @(posedge clk);
        #1;
        check(name, exp_reg);
    endtask

    task automatic drive(input logic v, input logic [3:0] ic, input logic [3:0] fn,
                         input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
        in_valid = v;
        icode    = ic;
        ifun     = fn;
        valA     = a;
        valB     = b;
        valC     = c;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        string       name;
        logic [3:0]  ic;
        logic [3:0]  fn;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] c;
        logic [63:0] exp_a;
        logic [63:0] exp_b;
        logic [1:0]  exp_f;
        logic        exp_e;
    } vec_t;

    vec_t vecs [14];

    initial begin
        n_total = 0;
        n_pass  = 0;

        a_kind = '{0, 0, 1, 2, 2, 2, 1, 0, 3, 4, 3, 4, 0, 0, 0, 0};
        b_uses = '{0, 0, 0, 0, 1, 1, 1, 0, 1, 1, 1, 1, 0, 0, 0, 0};
`ifdef ALU_SEL_IADDQ_EN
        a_kind[12] = 2;
        b_uses[12] = 1'b1;
`endif

        vecs[0]  = '{"opq_sub",  4'h6, 4'h1, 64'd3,    64'd10,    64'd99,     64'd3,    64'd10,    2'd1, 1'b0};
        vecs[1]  = '{"opq_xor",  4'h6, 4'h3, 64'd3,    64'd10,    64'd99,     64'd3,    64'd10,    2'd3, 1'b0};
        vecs[2]  = '{"opq_bad",  4'h6, 4'h7, 64'd3,    64'd10,    64'd99,     64'd3,    64'd10,    2'd0, 1'b1};
        vecs[3]  = '{"irmovq",   4'h3, 4'h5, 64'hAA,   64'hBB,    64'h1234,   64'h1234, 64'd0,     2'd0, 1'b0};
        vecs[4]  = '{"rrmovq",   4'h2, 4'h4, 64'h55,   64'h66,    64'h77,     64'h55,   64'd0,     2'd0, 1'b0};
        vecs[5]  = '{"mrmovq",   4'h5, 4'h0, 64'h1,    64'h100,   64'd16,     64'd16,   64'h100,   2'd0, 1'b0};
        vecs[6]  = '{"pushq",    4'hA, 4'h0, 64'h1,    64'h200,   64'h3,      64'hFFFF_FFFF_FFFF_FFF8, 64'h200, 2'd0, 1'b0};
        vecs[7]  = '{"ret",      4'h9, 4'h0, 64'h1,    64'h1F8,   64'h3,      64'd8,    64'h1F8,   2'd0, 1'b0};
`ifdef ALU_SEL_IADDQ_EN
        vecs[8]  = '{"iaddq",    4'hC, 4'h2, 64'h5,    64'd9,     64'd7,      64'd7,    64'd9,     2'd0, 1'b0};
`else
        vecs[8]  = '{"iaddq",    4'hC, 4'h2, 64'h5,    64'd9,     64'd7,      64'd0,    64'd0,     2'd0, 1'b0};
`endif
        vecs[9]  = '{"halt",     4'h0, 4'h6, 64'h5,    64'h9,     64'h7,      64'd0,    64'd0,     2'd0, 1'b0};
        vecs[10] = '{"nop",      4'h1, 4'h3, 64'h5,    64'h9,     64'h7,      64'd0,    64'd0,     2'd0, 1'b0};
        vecs[11] = '{"jxx",      4'h7, 4'h1, 64'h5,    64'h9,     64'h7,      64'd0,    64'd0,     2'd0, 1'b0};
        vecs[12] = '{"unk_f",    4'hF, 4'h6, 64'h5,    64'h9,     64'h7,      64'd0,    64'd0,     2'd0, 1'b0};
        vecs[13] = '{"call",     4'h8, 4'hF, 64'h5,    64'h400,   64'h7,      64'hFFFF_FFFF_FFFF_FFF8, 64'h400, 2'd0, 1'b0};

        // Reset with live inputs and stall asserted: reset must win.
        rst   = 1'b1;
        stall = 1'b1;
        drive(1'b1, 4'h6, 4'h0, 64'd5, 64'd6, 64'd7);
        step("reset");
        step("reset_hold");
        check("reset_zero", '0);
        rst   = 1'b0;
        stall = 1'b0;

        // Directed table: each vector checked against its own expected fields
        // and against the model.
        for (int i = 0; i < 14; i++) begin
            drive(1'b1, vecs[i].ic, vecs[i].fn, vecs[i].a, vecs[i].b, vecs[i].c);
            step(vecs[i].name);
            check({vecs[i].name, "_tbl"},
                  {1'b1, vecs[i].exp_e, vecs[i].exp_f, vecs[i].exp_b, vecs[i].exp_a});
        end

        // Stall holds every output while the inputs change underneath.
        drive(1'b1, 4'h6, 4'h2, 64'h77, 64'h11, 64'h22);
        step("stall_load");
        check("stall_load_tbl", {1'b1, 1'b0, 2'd2, 64'h11, 64'h77});
        stall = 1'b1;
        drive(1'b0, 4'h3, 4'h0, 64'h1, 64'h2, 64'h3333);
        for (int i = 0; i < 3; i++) begin
            step("stall_hold");
            check("stall_hold_tbl", {1'b1, 1'b0, 2'd2, 64'h11, 64'h77});
        end
        stall = 1'b0;
        step("stall_release");
        check("stall_release_tbl", {1'b0, 1'b0, 2'd0, 64'd0, 64'h3333});

        // in_valid=0 still loads data but clears out_valid.
        drive(1'b0, 4'hA, 4'h0, 64'h1, 64'h500, 64'h3);
        step("invalid_load");
        check("invalid_load_tbl", {1'b0, 1'b0, 2'd0, 64'h500, 64'hFFFF_FFFF_FFFF_FFF8});

        // Mid-stream reset clears the stage; first load lands on the next edge.
        drive(1'b1, 4'h6, 4'h3, 64'h9, 64'h8, 64'h7);
        step("pre_reset");
        rst = 1'b1;
        step("mid_reset");
        check("mid_reset_tbl", '0);
        rst = 1'b0;
        step("post_reset");
        check("post_reset_tbl", {1'b1, 1'b0, 2'd3, 64'h8, 64'h9});

        // Randomized phase with occasional stall and reset.
        for (int i = 0; i < 300; i++) begin
            rst   = ($urandom_range(0, 29) == 0);
            stall = ($urandom_range(0, 4) == 0);
            drive($urandom_range(0, 1), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
            step("random");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
